// File: rtl/sprite_dma.sv
// sprite_dma: copies or zero-fills the 128-byte sprite attribute table
// into sprite RAM, writing only inside vblank so the engine never scans a torn table.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   vblank                vertical blank (clk domain)
//   dma_start/dma_clear   start pulse; clear=1 zero-fills, clear=0 copies
//   dma_src_page          source page, table read from {page,8'h00}
//   bus_ack / bus_req     CPU bus grant / request
//   src_addr / src_data   work-RAM read port (data 1 cycle after address)
//   spriteram_*           sprite RAM write port
//   busy, done, overrun   status (overrun sticky until next start)
module sprite_dma #(
  parameter int SPRITE_COUNT  = 32,
  parameter int BYTES_PER_SPR = 4,
  parameter int TABLE_AW      = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vblank,
  input  logic                dma_start,
  input  logic                dma_clear,
  input  logic [7:0]          dma_src_page,
  input  logic                bus_ack,
  input  logic [7:0]          src_data,
  output logic                bus_req,
  output logic [15:0]         src_addr,
  output logic [TABLE_AW-1:0] spriteram_addr,
  output logic [7:0]          spriteram_data_in,
  output logic                spriteram_wr,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int TABLE_LEN = SPRITE_COUNT * BYTES_PER_SPR;
  localparam logic [TABLE_AW-1:0] LAST =
    TABLE_AW'(TABLE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_REQ,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [TABLE_AW-1:0] r_cnt;
  logic [7:0]          r_page;
  logic                r_clear;
  logic                r_vblank_last;

  logic w_vb_rise;
  logic w_stall;
  logic w_active;
  logic w_last;

  assign w_vb_rise = vblank & ~r_vblank_last;
  // Clear mode never owns the bus, so a missing grant cannot stall it.
  assign w_stall   = ~r_clear & ~bus_ack;
  assign w_active  = (r_state == S_REQ)  ||
                     (r_state == S_READ) ||
                     (r_state == S_WAIT) ||
                     (r_state == S_WRITE);
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_page            <= '0;
      r_clear           <= 1'b0;
      r_vblank_last     <= 1'b0;
      bus_req           <= 1'b0;
      src_addr          <= '0;
      spriteram_addr    <= '0;
      spriteram_data_in <= '0;
      spriteram_wr      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      r_vblank_last <= vblank;
      spriteram_wr  <= 1'b0;
      done          <= 1'b0;

      // Losing vblank mid-table: drop everything and redo the
      // whole table on the next vblank.
      if (w_active && !vblank) begin
        overrun <= 1'b1;
        bus_req <= 1'b0;
        r_cnt   <= '0;
        r_state <= S_ARMED;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (dma_start) begin
              r_page  <= dma_src_page;
              r_clear <= dma_clear;
              r_cnt   <= '0;
              overrun <= 1'b0;
              busy    <= 1'b1;
              r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (w_vb_rise)
              r_state <= r_clear ? S_WRITE : S_REQ;
          end
          S_REQ: begin
            bus_req <= 1'b1;
            if (bus_ack)
              r_state <= S_READ;
          end
          S_READ: begin
            if (!w_stall) begin
              src_addr <= {r_page, 8'(r_cnt)};
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!w_stall)
              r_state <= S_WRITE;
          end
          S_WRITE: begin
            // Grant lost: re-run the RAM latency cycle after regrant.
            if (w_stall) begin
              r_state <= S_WAIT;
            end else begin
              spriteram_addr    <= r_cnt;
              spriteram_data_in <= r_clear ? 8'h00 : src_data;
              spriteram_wr      <= 1'b1;
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_cnt   <= r_cnt + TABLE_AW'(1);
                r_state <= r_clear ? S_WRITE : S_READ;
              end
            end
          end
          S_DONE: begin
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: table-driven transfer scenarios plus reset
// and reset-mid-transfer sequences for sprite_dma.
module tb_sprite_dma;

  logic        clk;
  logic        reset_n;
  logic        vblank;
  logic        dma_start;
  logic        dma_clear;
  logic [7:0]  dma_src_page;
  logic        bus_ack;
  logic [7:0]  src_data;
  logic        bus_req;
  logic [15:0] src_addr;
  logic [6:0]  spriteram_addr;
  logic [7:0]  spriteram_data_in;
  logic        spriteram_wr;
  logic        busy;
  logic        done;
  logic        overrun;

  sprite_dma dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .vblank            (vblank),
    .dma_start         (dma_start),
    .dma_clear         (dma_clear),
    .dma_src_page      (dma_src_page),
    .bus_ack           (bus_ack),
    .src_data          (src_data),
    .bus_req           (bus_req),
    .src_addr          (src_addr),
    .spriteram_addr    (spriteram_addr),
    .spriteram_data_in (spriteram_data_in),
    .spriteram_wr      (spriteram_wr),
    .busy              (busy),
    .done              (done),
    .overrun           (overrun)
  );

  typedef struct {
    bit         clr;
    logic [7:0] page;
    int         stall_at;
    int         ovr_at;
    bit         dup;
    int         e_wr;
    int         e_run;
    int         e_span;
    int         e_breq;
    int         e_ovr;
  } vec_t;

  vec_t tv[6];

  int n_pass = 0;
  int n_tot  = 0;

  int wr_total, run, maxrun, first_cyc, last_cyc, cyc;
  int breq_seen, wr_outvb, wr_stall, bit7_bad;
  logic [7:0] sram [128];

  int   stall_at   = -1;
  int   stall_left = 0;
  bit   stall_done = 0;
  int   req_cnt    = 0;
  logic [15:0] addr_q = '0;

  bit got_done;
  bit busy_at_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h40;
  endfunction

  function automatic logic [7:0] exp_byte(input vec_t v,
                                          input int n);
    logic [7:0] nb;
    nb = 8'(n);
    if (v.clr) return 8'h00;
    return nb ^ 8'hA5 ^ v.page ^ 8'h40;
  endfunction

  // Bus arbiter and work-RAM model (1-cycle read latency).
  initial begin
    bus_ack  = 1'b0;
    src_data = 8'h00;
    forever begin
      @(negedge clk);
      src_data = src_fn(addr_q);
      addr_q   = src_addr;
      if (!bus_req) begin
        req_cnt = 0;
        bus_ack = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        bus_ack = (stall_left == 0);
      end else if (bus_ack && !stall_done && stall_at >= 0 &&
                   src_addr[6:0] == stall_at[6:0]) begin
        stall_done = 1;
        stall_left = 5;
        bus_ack    = 1'b0;
      end else begin
        req_cnt++;
        if (req_cnt >= 2) bus_ack = 1'b1;
      end
    end
  end

  // Sprite RAM model and write monitor.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (spriteram_wr) begin
        sram[spriteram_addr] = spriteram_data_in;
        if (wr_total == 0) first_cyc = cyc;
        last_cyc = cyc;
        wr_total++;
        run++;
        if (run > maxrun) maxrun = run;
        if (!vblank) wr_outvb++;
        if (bus_req && !bus_ack) wr_stall++;
      end else begin
        run = 0;
      end
      if (bus_req) begin
        breq_seen = 1;
        if (src_addr[7]) bit7_bad++;
      end
    end
  end

  task automatic clear_mon();
    wr_total  = 0;
    run       = 0;
    maxrun    = 0;
    first_cyc = 0;
    last_cyc  = 0;
    breq_seen = 0;
    wr_outvb  = 0;
    wr_stall  = 0;
    bit7_bad  = 0;
    for (int i = 0; i < 128; i++) sram[i] = 8'h77;
  endtask

  task automatic pulse_start(input bit clr,
                             input logic [7:0] pg);
    dma_start    = 1'b1;
    dma_clear    = clr;
    dma_src_page = pg;
    @(negedge clk);
    dma_start    = 1'b0;
    dma_clear    = 1'b0;
    dma_src_page = 8'h00;
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int k;
    clear_mon();
    stall_at   = v.stall_at;
    stall_done = 0;
    @(negedge clk);
    pulse_start(v.clr, v.page);
    repeat (3) @(negedge clk);
    if (v.dup) pulse_start(~v.clr, 8'h50);
    chk({tag, "_armed_busy"}, busy, 1);
    chk({tag, "_armed_nowr"}, wr_total, 0);
    vblank = 1'b1;
    if (v.ovr_at >= 0) begin
      k = 0;
      while (wr_total < v.ovr_at && k < 2000) begin
        @(negedge clk);
        k++;
      end
      vblank = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_ovr_flag"}, overrun, 1);
      chk({tag, "_ovr_breq"}, bus_req, 0);
      chk({tag, "_ovr_busy"}, busy, 1);
      repeat (5) @(negedge clk);
      vblank = 1'b1;
    end
    k = 0;
    got_done     = 0;
    busy_at_done = 1;
    while (!got_done && k < 2000) begin
      @(negedge clk);
      k++;
      if (done) begin
        got_done     = 1;
        busy_at_done = busy;
      end
    end
    @(negedge clk);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_xfer(input vec_t v, input string tag);
    int errs;
    errs = 0;
    for (int n = 0; n < 128; n++)
      if (sram[n] !== exp_byte(v, n)) errs++;
    chk({tag, "_done"},     got_done, 1);
    chk({tag, "_busy_end"}, busy_at_done, 0);
    chk({tag, "_nwr"},      wr_total, v.e_wr);
    chk({tag, "_data_err"}, errs, 0);
    chk({tag, "_maxrun"},   maxrun, v.e_run);
    if (v.e_span >= 0)
      chk({tag, "_span"}, last_cyc - first_cyc, v.e_span);
    chk({tag, "_breq"},     breq_seen, v.e_breq);
    chk({tag, "_overrun"},  overrun, v.e_ovr);
    chk({tag, "_wr_novb"},  wr_outvb, 0);
    chk({tag, "_wr_stall"}, wr_stall, 0);
    chk({tag, "_src_bit7"}, bit7_bad, 0);
  endtask

  initial begin
    int k;
    //        clr  page   stall ovr  dup  wr   run  span brq ovr
    tv[0] = '{1'b0, 8'h40, -1, -1, 1'b0, 128, 1,   381, 1, 0};
    tv[1] = '{1'b1, 8'h40, -1, -1, 1'b0, 128, 128, 127, 0, 0};
    tv[2] = '{1'b0, 8'h40, 40, -1, 1'b0, 128, 1,   386, 1, 0};
    tv[3] = '{1'b0, 8'h40, -1, 60, 1'b0, 188, 1,   -1,  1, 1};
    tv[4] = '{1'b0, 8'h13, -1, -1, 1'b0, 128, 1,   381, 1, 0};
    tv[5] = '{1'b0, 8'h40, -1, -1, 1'b1, 128, 1,   381, 1, 0};

    reset_n      = 1'b0;
    vblank       = 1'b0;
    dma_start    = 1'b0;
    dma_clear    = 1'b0;
    dma_src_page = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        longint'({bus_req, src_addr, spriteram_addr,
                  spriteram_data_in, spriteram_wr,
                  busy, done, overrun}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_xfer(tv[i], $sformatf("v%0d", i));
      check_xfer(tv[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of a copy, then a normal copy.
    clear_mon();
    stall_at   = -1;
    stall_done = 0;
    @(negedge clk);
    pulse_start(1'b0, 8'h40);
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    k = 0;
    while (wr_total < 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached20", wr_total, 20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        longint'({bus_req, src_addr, spriteram_addr,
                  spriteram_data_in, spriteram_wr,
                  busy, done, overrun}), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_nowr", wr_total, 20);
    reset_n = 1'b1;
    vblank  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle", busy, 0);
    run_xfer(tv[0], "post_rst");
    check_xfer(tv[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
